iob_cpu_bus_arbiter: RTL
========================

// Module: iob_cpu_bus_arbiter
// PURPOSE
//   Two-master, one-slave arbiter for the CPU native memory bus. Merges the PicoRV32
//   instruction bus (i_*) and data bus (d_*) onto one shared memory port (m_*), e.g. a
//   single-ported SRAM or the DDR path. Holds the grant for a whole transaction.
//   Selects round-robin or fixed data-priority. A watchdog terminates stalled transfers.
// PARAMETERS
//   ADDR_W     32  address width of all ports
//   DATA_W     32  data width; wstrb width is DATA_W/8
//   PRIO_D     0   0: round-robin between i and d; 1: d always wins a tie
//   TIMEOUT_W  8   watchdog counter width; transfer aborted after 2**TIMEOUT_W-1 wait cycles; 0 disables
// PORTS
//   clk      in   1         clock, all state on rising edge
//   resetn   in   1         asynchronous, active-low reset
//   i_valid  in   1         ibus request; held with addr/wdata/wstrb stable until i_ready
//   i_addr   in   ADDR_W    ibus address
//   i_wdata  in   DATA_W    ibus write data
//   i_wstrb  in   DATA_W/8  ibus byte strobes (0 = read)
//   i_rdata  out  DATA_W    ibus read data, valid when i_ready
//   i_ready  out  1         ibus 1-cycle completion pulse
//   d_valid/d_addr/d_wdata/d_wstrb/d_rdata/d_ready   same as i_*, for dbus
//   m_valid  out  1         shared-port request
//   m_addr   out  ADDR_W    granted master address
//   m_wdata  out  DATA_W    granted master write data
//   m_wstrb  out  DATA_W/8  granted master strobes
//   m_rdata  in   DATA_W    slave read data, valid with m_ready
//   m_ready  in   1         slave 1-cycle completion pulse
//   busy     out  1         high while in BUSY state
//   timeout  out  1         sticky: set on any watchdog abort, cleared only by reset
// BEHAVIOUR
//   - Reset (async, resetn=0): state=IDLE, m_valid=0, i_ready=d_ready=0, busy=0,
//     timeout=0, wdog=0, sel_q=I, last_q=D, so ibus wins the first tie. Takes effect
//     immediately, mid-transfer included. The in-flight transfer is dropped with no ready pulse.
//   - FSM IDLE: m_valid=0, m_ready ignored. If i_valid|d_valid: register winner into sel_q,
//     set last_q=winner, wdog=0, go BUSY. Arbitration latency: 1 cycle.
//   - Winner: only one valid -> that one. Both valid: PRIO_D=1 -> D. PRIO_D=0 -> the master
//     not equal to last_q.
//   - FSM BUSY: m_valid = ~m_ready, masked in the completion cycle. m_addr/m_wdata/m_wstrb
//     are combinationally muxed from sel_q. Non-granted master sees ready=0.
//   - Completion: m_ready=1 in BUSY -> same cycle, <sel>_ready=1 and <sel>_rdata=m_rdata,
//     combinational pass-through. Next state IDLE. Other-master rdata is 0 at all times.
//   - Throughput: min 3 cycles per transfer (IDLE, BUSY, BUSY+ready when slave has 1-cycle
//     latency). Back-to-back requests from the other master are granted at the next IDLE.
//   - m_addr/m_wdata/m_wstrb outside BUSY are 0.
//   - Watchdog (TIMEOUT_W>0): wdog increments each BUSY cycle with m_ready=0.
//     At wdog==2**TIMEOUT_W-1 with m_ready=0: m_valid=0, <sel>_ready=1 with <sel>_rdata=0,
//     timeout<=1, next IDLE. m_ready arriving on that same cycle wins: normal completion,
//     no timeout flag.
//   - Master dropping valid while granted is a protocol violation. The transfer still runs
//     to completion; no recovery is defined.
//   - Slave must not pulse m_ready outside BUSY. Such a pulse is ignored.
//   - Registers: state, sel_q, last_q, wdog[TIMEOUT_W], timeout. All other outputs are
//     combinational from these and the inputs.
// TESTING
//   1 ibus read only: i_valid=1 @A=0x100, slave ready after 2 cycles with 0xDEADBEEF
//     -> m_addr=0x100; i_ready pulses once with i_rdata=0xDEADBEEF; d_ready stays 0.
//   2 both valid every cycle, PRIO_D=0, 4 transfers -> grant order I,D,I,D; never two
//     consecutive grants to one master.
//   3 PRIO_D=1, both valid, 3 transfers -> all granted to D; I served only once d_valid=0.
//   4 dbus write A=0x2000, wdata=0x12345678, wstrb=4'b0011 -> m_wstrb=0011 and m_wdata
//     exact; d_ready pulses exactly one cycle.
//   5 TIMEOUT_W=4, slave never ready -> abort after 15 wait cycles; d_ready=1 with
//     d_rdata=0; timeout=1 and stays 1; next request is served normally.
//   6 resetn=0 mid-BUSY -> m_valid, busy, ready outputs 0 immediately; after release,
//     pending i and d requests -> ibus granted first.

Source files
------------

// File: rtl/iob_cpu_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave arbiter for the native CPU memory bus.
// Grant is held for a whole transaction; a watchdog aborts transfers the slave never completes.
module iob_cpu_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_D    = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                busy,
  output logic                timeout
);

  localparam int   WD_W  = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic            sel_q, sel_nxt;
  logic            last_q, last_nxt;
  logic [WD_W-1:0] wdog, wdog_nxt;
  logic            timeout_nxt;
  logic            winner;
  logic            wdog_hit;
  logic            fin;
  logic [DATA_W-1:0] rdata_fin;

  // Tie-break: data priority, or round-robin away from the last granted master.
  function automatic logic pick(input logic iv, input logic dv, input logic last);
    if (iv && dv) return (PRIO_D != 0) ? SEL_D : ~last;
    return dv ? SEL_D : SEL_I;
  endfunction

  assign winner   = pick(i_valid, d_valid, last_q);
  assign wdog_hit = (TIMEOUT_W > 0) && (wdog == {WD_W{1'b1}});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sel_q   <= SEL_I;
      last_q  <= SEL_D;
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_q   <= sel_nxt;
      last_q  <= last_nxt;
      wdog    <= wdog_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    last_nxt    = last_q;
    wdog_nxt    = wdog;
    timeout_nxt = timeout;
    busy        = 1'b0;
    m_valid     = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    fin         = 1'b0;
    rdata_fin   = '0;
    case (state)
      IDLE: begin
        if (i_valid || d_valid) begin
          sel_nxt   = winner;
          last_nxt  = winner;
          wdog_nxt  = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy    = 1'b1;
        m_addr  = (sel_q == SEL_D) ? d_addr  : i_addr;
        m_wdata = (sel_q == SEL_D) ? d_wdata : i_wdata;
        m_wstrb = (sel_q == SEL_D) ? d_wstrb : i_wstrb;
        // A slave response in the watchdog's last cycle still counts as a normal completion.
        if (m_ready) begin
          fin       = 1'b1;
          rdata_fin = m_rdata;
          state_nxt = IDLE;
        end else if (wdog_hit) begin
          fin         = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          m_valid  = 1'b1;
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    i_ready = fin && (sel_q == SEL_I);
    d_ready = fin && (sel_q == SEL_D);
    i_rdata = i_ready ? rdata_fin : '0;
    d_rdata = d_ready ? rdata_fin : '0;
  end

endmodule
